// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: operand forwarding, load-use/MD stall, branch/jump flush,
// multiply/divide occupancy tracking and saturating stall/flush event counters.
module pipeline_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_md,
    input  logic              id_reads_hilo,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    logic             load_use, md_hazard, stall, md_accept;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             unused;

    // ex_reg_write carries no hazard meaning here: a load always writes ex_rd
    assign unused = ex_reg_write;

    always_comb begin
        forward_a = (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs) ? 2'b10 :
                    (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs)    ? 2'b01 : 2'b00;
        forward_b = (mem_reg_write && mem_rd != '0 && mem_rd == ex_rt) ? 2'b10 :
                    (wb_reg_write && wb_rd != '0 && wb_rd == ex_rt)    ? 2'b01 : 2'b00;
        load_use  = ex_mem_read && ex_rd != '0 &&
                    ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        md_hazard = md_busy && (id_is_md || id_reads_hilo);
        stall     = !reset && (load_use || md_hazard) && !ex_branch_taken;
        // a taken branch overrides stalls; a jump only flushes when nothing else holds ID
        flush_if_id  = !reset && (ex_branch_taken || (id_jump && !stall));
        bubble_id_ex = !reset && (ex_branch_taken || stall);
        stall_pc     = stall;
        stall_if_id  = stall;
        md_accept    = !reset && id_is_md && !stall && !ex_branch_taken;
        md_cnt_d     = md_accept ? 4'(MD_LATENCY) : md_cnt_q - {3'b000, md_cnt_q != 4'd0};
        stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall && stall_cnt_q != '1};
        flush_cnt_d  = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_if_id && flush_cnt_q != '1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign md_busy     = md_cnt_q != 4'd0;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: table-driven combinational vectors plus hand-written
// multi-cycle sequences for counters, MD occupancy, saturation and reset.
module tb_pipeline_hazard_unit;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo, id_jump;
    logic          ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;
    logic [1:0]    forward_a, forward_b;
    logic          stall_pc, stall_if_id, bubble_id_ex, flush_if_id, md_busy;
    logic [CW-1:0] stall_count, flush_count;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_unit #(.REG_AW(AW), .MD_LATENCY(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .forward_a(forward_a), .forward_b(forward_b), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .md_busy(md_busy), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id_rs, id_rt, urs, urt, jmp;
        int ex_rs, ex_rt, ex_rd, mr, br;
        int mem_rd, mw, wb_rd, ww;
        int fa, fb, st, bub, fl;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic clr();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo, id_jump} = '0;
        {ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write} = '0;
    endtask

    task automatic load_use_in();
        ex_mem_read = 1'b1;
        ex_reg_write = 1'b1;
        ex_rd = 5'd8;
        id_rt = 5'd8;
        id_uses_rt = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input int st, input int bub, input int fl);
        chk({name, ".stall_pc"}, int'(stall_pc), st);
        chk({name, ".stall_if_id"}, int'(stall_if_id), st);
        chk({name, ".bubble_id_ex"}, int'(bubble_id_ex), bub);
        chk({name, ".flush_if_id"}, int'(flush_if_id), fl);
    endtask

    initial begin
        //          ids irt urs urt jmp exs ext exd mr br  mrd mw wrd ww  fa fb st bub fl
        vecs[0]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  0};
        vecs[1]  = '{0,  0,  0,  0,  0,  3,  0,  0,  0, 0,  3,  1, 3,  1,  2, 0, 0, 0,  0};
        vecs[2]  = '{0,  0,  0,  0,  0,  3,  0,  0,  0, 0,  3,  0, 3,  1,  1, 0, 0, 0,  0};
        vecs[3]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0, 0,  3,  1, 3,  1,  0, 0, 0, 0,  0};
        vecs[4]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0, 0,  0,  1, 0,  1,  0, 0, 0, 0,  0};
        vecs[5]  = '{0,  0,  0,  0,  0,  9,  7,  0,  0, 0,  7,  1, 9,  1,  1, 2, 0, 0,  0};
        vecs[6]  = '{0,  8,  0,  1,  0,  0,  0,  8,  1, 0,  0,  0, 0,  0,  0, 0, 1, 1,  0};
        vecs[7]  = '{0,  8,  0,  0,  0,  0,  0,  8,  1, 0,  0,  0, 0,  0,  0, 0, 0, 0,  0};
        vecs[8]  = '{12, 0,  1,  0,  0,  0,  0, 12,  1, 0,  0,  0, 0,  0,  0, 0, 1, 1,  0};
        vecs[9]  = '{0,  0,  1,  1,  0,  0,  0,  0,  1, 0,  0,  0, 0,  0,  0, 0, 0, 0,  0};
        vecs[10] = '{0,  8,  0,  1,  0,  0,  0,  8,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  0};
        vecs[11] = '{0,  8,  0,  1,  0,  0,  0,  8,  1, 1,  0,  0, 0,  0,  0, 0, 0, 1,  1};
        vecs[12] = '{0,  0,  0,  0,  1,  0,  0,  0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  1};
        vecs[13] = '{0,  8,  0,  1,  1,  0,  0,  8,  1, 0,  0,  0, 0,  0,  0, 0, 1, 1,  0};
        vecs[14] = '{0,  0,  0,  0,  1,  0,  0,  0,  0, 1,  0,  0, 0,  0,  0, 0, 0, 1,  1};
        vecs[15] = '{0,  0,  0,  0,  0,  5,  5,  0,  0, 0,  5,  0, 5,  1,  1, 1, 0, 0,  0};

        clr();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset.md_busy", int'(md_busy), 0);
        chk("reset.stall_count", int'(stall_count), 0);
        chk("reset.flush_count", int'(flush_count), 0);

        for (int i = 0; i < 16; i++) begin
            id_rs = vecs[i].id_rs[AW-1:0];    id_rt = vecs[i].id_rt[AW-1:0];
            id_uses_rs = vecs[i].urs[0];      id_uses_rt = vecs[i].urt[0];
            id_jump = vecs[i].jmp[0];
            ex_rs = vecs[i].ex_rs[AW-1:0];    ex_rt = vecs[i].ex_rt[AW-1:0];
            ex_rd = vecs[i].ex_rd[AW-1:0];    ex_mem_read = vecs[i].mr[0];
            ex_reg_write = vecs[i].mr[0];     ex_branch_taken = vecs[i].br[0];
            mem_rd = vecs[i].mem_rd[AW-1:0];  mem_reg_write = vecs[i].mw[0];
            wb_rd = vecs[i].wb_rd[AW-1:0];    wb_reg_write = vecs[i].ww[0];
            #1;
            chk($sformatf("vec%0d.forward_a", i), int'(forward_a), vecs[i].fa);
            chk($sformatf("vec%0d.forward_b", i), int'(forward_b), vecs[i].fb);
            chk_ctl($sformatf("vec%0d", i), vecs[i].st, vecs[i].bub, vecs[i].fl);
            step();
        end

        // hazard controls are masked while reset is high
        clr();
        load_use_in();
        id_jump = 1'b1;
        reset = 1'b1;
        #1;
        chk_ctl("in_reset", 0, 0, 0);
        ex_branch_taken = 1'b1;
        #1;
        chk_ctl("in_reset_br", 0, 0, 0);
        step();
        reset = 1'b0;
        clr();
        #1;
        chk("post_reset.stall_count", int'(stall_count), 0);
        chk("post_reset.flush_count", int'(flush_count), 0);

        // single load-use stall
        load_use_in();
        #1;
        chk_ctl("load_use", 1, 1, 0);
        step();
        chk("load_use.stall_count", int'(stall_count), 1);
        clr();
        #1;
        chk_ctl("load_use_gone", 0, 0, 0);

        // branch beats the stall
        load_use_in();
        ex_branch_taken = 1'b1;
        #1;
        chk_ctl("branch_over_stall", 0, 1, 1);
        step();
        chk("branch.flush_count", int'(flush_count), 1);
        chk("branch.stall_count", int'(stall_count), 1);
        clr();

        // MD occupancy: accepted at edge t, busy for 4 cycles
        id_is_md = 1'b1;
        #1;
        chk("md.pre_busy", int'(md_busy), 0);
        chk("md.accept_no_stall", int'(stall_pc), 0);
        step();
        id_is_md = 1'b0;
        id_reads_hilo = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("md.busy%0d", k), int'(md_busy), 1);
            chk($sformatf("md.hilo_stall%0d", k), int'(stall_pc), 1);
            step();
        end
        chk("md.idle_busy", int'(md_busy), 0);
        chk("md.idle_stall", int'(stall_pc), 0);
        step();
        chk("md.t5_stall", int'(stall_pc), 0);
        chk("md.stall_count", int'(stall_count), 5);

        // MD instruction flushed by a branch or held by a stall never starts
        clr();
        id_is_md = 1'b1;
        ex_branch_taken = 1'b1;
        step();
        chk("md_flushed.busy", int'(md_busy), 0);
        chk("md_flushed.flush_count", int'(flush_count), 2);
        ex_branch_taken = 1'b0;
        load_use_in();
        step();
        chk("md_held.busy", int'(md_busy), 0);
        chk("md_held.stall_count", int'(stall_count), 6);

        // reset mid-operation with md_cnt = 2 and stall_count = 5
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_use_in();
        repeat (5) step();
        clr();
        id_is_md = 1'b1;
        step();
        clr();
        step();
        step();
        chk("mid.stall_count", int'(stall_count), 5);
        chk("mid.md_busy", int'(md_busy), 1);
        load_use_in();
        id_jump = 1'b1;
        id_reads_hilo = 1'b1;
        reset = 1'b1;
        #1;
        chk_ctl("mid.in_reset", 0, 0, 0);
        step();
        reset = 1'b0;
        clr();
        #1;
        chk("mid.after_md_busy", int'(md_busy), 0);
        chk("mid.after_stall_count", int'(stall_count), 0);
        chk("mid.after_flush_count", int'(flush_count), 0);

        // saturation of both counters
        load_use_in();
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) chk("sat.stall14", int'(stall_count), 14);
            if (i == 14) chk("sat.stall15", int'(stall_count), 15);
        end
        chk("sat.stall_hold", int'(stall_count), 15);
        clr();
        ex_branch_taken = 1'b1;
        repeat (20) step();
        chk("sat.flush_hold", int'(flush_count), 15);
        chk("sat.stall_after_flush", int'(stall_count), 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
